// File: rtl/mod_counter_chain.sv
// Cascaded up/down modulo counter: DIGITS digits of radix RADIX, ripple carry/borrow, clear, clamped load, sticky wrap.
// Latency: one clock from clr/load/inc/dec to count; carry_o/borrow_o/zero_o are combinational from the current count.
// Backpressure: none; every step is accepted. Define CNT_SATURATE_EN to saturate at all-max/all-zero instead of wrapping.
module mod_counter_chain #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10,
    parameter int WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] load_val,
    input  logic                    inc,
    input  logic                    dec,
    output logic [DIGITS*WIDTH-1:0] count,
    output logic                    carry_o,
    output logic                    borrow_o,
    output logic                    zero_o,
    output logic                    wrap_o
);

    // Largest legal digit value; RADIX may equal 2**WIDTH, so RADIX itself is never used as a WIDTH-bit constant.
    localparam logic [WIDTH-1:0] DMAX = WIDTH'(RADIX - 1);

    logic                    up_step;
    logic                    dn_step;
    logic [DIGITS-1:0]       dig_max;
    logic [DIGITS-1:0]       dig_zero;
    logic [DIGITS-1:0]       up_en;
    logic [DIGITS-1:0]       dn_en;
    logic                    all_max;
    logic                    all_zero;
    logic [DIGITS*WIDTH-1:0] step_val;
    logic [DIGITS*WIDTH-1:0] load_clamped;

    assign up_step = inc & ~dec;
    assign dn_step = dec & ~inc;

    // Per-digit extreme detection and the ripple enables: a digit moves only when all lower digits are at the extreme.
    always_comb begin
        dig_max  = '0;
        dig_zero = '0;
        up_en    = '0;
        dn_en    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_max[i]  = (count[i*WIDTH +: WIDTH] == DMAX);
            dig_zero[i] = (count[i*WIDTH +: WIDTH] == '0);
        end
        up_en[0] = 1'b1;
        dn_en[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            up_en[i] = up_en[i-1] & dig_max[i-1];
            dn_en[i] = dn_en[i-1] & dig_zero[i-1];
        end
    end

    assign all_max  = &dig_max;
    assign all_zero = &dig_zero;

    // Next count for a single up or down step across the whole chain.
    always_comb begin
        logic [WIDTH-1:0] d;
        d        = '0;
        step_val = count;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[i*WIDTH +: WIDTH];
            if (up_step && up_en[i]) begin
                step_val[i*WIDTH +: WIDTH] = dig_max[i] ? '0 : d + WIDTH'(1);
            end else if (dn_step && dn_en[i]) begin
                step_val[i*WIDTH +: WIDTH] = dig_zero[i] ? DMAX : d - WIDTH'(1);
            end
        end
`ifdef CNT_SATURATE_EN
        // At the chain extreme the count holds instead of wrapping; carry/borrow still flag the event.
        if ((up_step && all_max) || (dn_step && all_zero)) begin
            step_val = count;
        end
`endif
    end

    // Load value with every out-of-range digit forced to the largest legal digit.
    always_comb begin
        logic [WIDTH-1:0] lv;
        lv           = '0;
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lv = load_val[i*WIDTH +: WIDTH];
            load_clamped[i*WIDTH +: WIDTH] = (lv > DMAX) ? DMAX : lv;
        end
    end

    assign carry_o  = up_step & all_max  & ~load & ~clr & rst_n;
    assign borrow_o = dn_step & all_zero & ~load & ~clr & rst_n;
    assign zero_o   = all_zero;

    // Count and sticky wrap register: reset, clear, load, then step, in that priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            wrap_o <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            wrap_o <= 1'b0;
        end else if (load) begin
            count  <= load_clamped;
        end else begin
            if (up_step || dn_step) begin
                count <= step_val;
            end
            if (carry_o || borrow_o) begin
                wrap_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_counter_chain.sv
// Randomized bench for mod_counter_chain: two instances (radix 10 and radix 16) share stimulus.
// Each is compared every cycle against an integer-valued model of the whole chain.
// Directed sequences pin the model with hand-computed literal values.
module tb_mod_counter_chain;

`ifdef CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;

    logic [15:0] count_a, count_b;
    logic        carry_a, borrow_a, zero_a, wrap_a;
    logic        carry_b, borrow_b, zero_b, wrap_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    // Model state: whole-chain value as an integer plus the sticky wrap flag.
    int mv[2];
    int mw[2];
    int rad[2] = '{10, 16};
    int modv[2] = '{10000, 65536};

    always #5 clk = ~clk;

    mod_counter_chain #(.DIGITS(4), .RADIX(10), .WIDTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .count(count_a), .carry_o(carry_a),
        .borrow_o(borrow_a), .zero_o(zero_a), .wrap_o(wrap_a)
    );

    mod_counter_chain #(.DIGITS(4), .RADIX(16), .WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .count(count_b), .carry_o(carry_b),
        .borrow_o(borrow_b), .zero_o(zero_b), .wrap_o(wrap_b)
    );

    function automatic logic [15:0] to_bus(input int val, input int r);
        logic [15:0] b;
        int v;
        b = '0;
        v = val;
        for (int i = 0; i < 4; i++) begin
            b[i*4 +: 4] = 4'(v % r);
            v = v / r;
        end
        return b;
    endfunction

    function automatic int from_load(input logic [15:0] lv, input int r);
        int val;
        int d;
        val = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(lv[i*4 +: 4]);
            if (d > r - 1) d = r - 1;
            val = val * r + d;
        end
        return val;
    endfunction

    function automatic bit exp_carry(input int k);
        return rst_n && !clr && !load && inc && !dec && (mv[k] == modv[k] - 1);
    endfunction

    function automatic bit exp_borrow(input int k);
        return rst_n && !clr && !load && dec && !inc && (mv[k] == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Model update on the same edge the DUT registers.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) begin
                mv[k] = 0;
                mw[k] = 0;
            end else if (load) begin
                mv[k] = from_load(load_val, rad[k]);
            end else if (inc && !dec) begin
                if (mv[k] == modv[k] - 1) begin
                    mw[k] = 1;
                    mv[k] = SAT ? mv[k] : 0;
                end else begin
                    mv[k] = mv[k] + 1;
                end
            end else if (dec && !inc) begin
                if (mv[k] == 0) begin
                    mw[k] = 1;
                    mv[k] = SAT ? 0 : modv[k] - 1;
                end else begin
                    mv[k] = mv[k] - 1;
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("a_count",  count_a,  to_bus(mv[0], 10));
            chk("a_carry",  carry_a,  exp_carry(0));
            chk("a_borrow", borrow_a, exp_borrow(0));
            chk("a_zero",   zero_a,   mv[0] == 0);
            chk("a_wrap",   wrap_a,   mw[0] != 0);
            chk("b_count",  count_b,  to_bus(mv[1], 16));
            chk("b_carry",  carry_b,  exp_carry(1));
            chk("b_borrow", borrow_b, exp_borrow(1));
            chk("b_zero",   zero_b,   mv[1] == 0);
            chk("b_wrap",   wrap_b,   mw[1] != 0);
        end
    end

    task automatic drive(input logic r, input logic c, input logic l,
                         input logic [15:0] lv, input logic i, input logic d);
        @(negedge clk);
        rst_n = r; clr = c; load = l; load_val = lv; inc = i; dec = d;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] lv;
        logic [15:0] picks [5];
        picks = '{16'h9999, 16'h0000, 16'hFFFF, 16'h0999, 16'h1000};

        // Reset held two cycles with inc asserted.
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk_en = 1'b1;
        idle(); #1;
        chk("lit_rst_count", count_a, 16'h0000);
        chk("lit_rst_wrap",  wrap_a,  1'b0);
        chk("lit_rst_zero",  zero_a,  1'b1);

        // Clear beats a pending increment.
        drive(1'b1, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(); #1;
        chk("lit_clr_count", count_a, 16'h0000);
        chk("lit_clr_wrap",  wrap_a,  1'b0);

        // Cascade up without full wrap.
        drive(1'b1, 1'b0, 1'b1, 16'h0999, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); #1;
        chk("lit_up_carry", carry_a, 1'b0);
        idle(); #1;
        chk("lit_up_count", count_a, 16'h1000);
        chk("lit_model_up", to_bus(mv[0], 10), 16'h1000);

        // Full-chain carry.
        drive(1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 0, 16'h0000, 1'b1, 1'b0); #1;
        chk("lit_wrap_carry", carry_a, 1'b1);
        idle(); #1;
        chk("lit_wrap_count", count_a, SAT ? 16'h9999 : 16'h0000);
        chk("lit_wrap_flag",  wrap_a,  1'b1);

        // Full-chain borrow from zero.
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1); #1;
        chk("lit_borrow", borrow_a, 1'b1);
        idle(); #1;
        chk("lit_borrow_count", count_a, SAT ? 16'h0000 : 16'h9999);
        chk("lit_borrow_wrap",  wrap_a,  1'b1);

        // Cascade down.
        drive(1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        idle(); #1;
        chk("lit_down_count", count_a, 16'h0999);

        // inc and dec together hold.
        drive(1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); #1;
        chk("lit_hold_carry", carry_a, 1'b0);
        idle(); #1;
        chk("lit_hold_count", count_a, 16'h0005);

        // Load beats inc; clear beats load.
        drive(1'b1, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0);
        idle(); #1;
        chk("lit_load_inc", count_a, 16'h0042);
        drive(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        idle(); #1;
        chk("lit_clr_load", count_a, 16'h0000);

        // Load clamping in both radices.
        drive(1'b1, 1'b0, 1'b1, 16'hFA39, 1'b0, 1'b0);
        idle(); #1;
        chk("lit_clamp_a", count_a, 16'h9939);
        chk("lit_clamp_b", count_b, 16'hFA39);

        // Radix 16 full wrap.
        drive(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); #1;
        chk("lit_b_carry", carry_b, 1'b1);
        idle(); #1;
        chk("lit_b_count", count_b, SAT ? 16'hFFFF : 16'h0000);

`ifdef CNT_SATURATE_EN
        // Saturation holds across repeated increments.
        drive(1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); #1;
            chk("lit_sat_carry", carry_a, 1'b1);
        end
        idle(); #1;
        chk("lit_sat_count", count_a, 16'h9999);
        chk("lit_sat_wrap",  wrap_a,  1'b1);
`endif

        // Randomized traffic, biased towards the chain extremes.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) lv = picks[$urandom_range(0, 4)];
            else lv = 16'($urandom);
            drive($urandom_range(0, 63) != 0,
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 7) == 0,
                  lv,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        idle();
        idle();
        #3;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mod_counter_chain.md
Name: mod_counter_chain

Overview:
Cascaded multi-digit up/down modulo counter. DIGITS digits of radix RADIX are packed into one bus, with ripple carry/borrow propagated between digits inside a single clock. Adds synchronous clear, parallel load with range clamping, and a sticky wrap flag. Used for byte/line/file counters in the serial echo path, e.g. a decimal display of bytes echoed.

Parameters:
DIGITS, 4, number of cascaded digits (>=1)
RADIX, 10, modulus of each digit (>=2, <=2**WIDTH)
WIDTH, 4, bits per digit

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
clr  input  1  synchronous clear of count and wrap_o
load  input  1  synchronous parallel load from load_val
load_val  input  DIGITS*WIDTH  load value; digit i = bits [i*WIDTH +: WIDTH]
inc  input  1  count up one step
dec  input  1  count down one step
count  output  DIGITS*WIDTH  registered count; digit 0 = least significant
carry_o  output  1  combinational; this inc wraps the whole chain from max to 0
borrow_o  output  1  combinational; this dec wraps the whole chain from 0 to max
zero_o  output  1  combinational; all digits == 0
wrap_o  output  1  registered sticky; set on any full-chain wrap

Behaviour:
- Reset (rst_n=0 at clk edge): count=0, wrap_o=0. Overrides all other inputs.
- Priority, highest first: rst_n, clr, load, inc/dec.
- clr=1: count=0, wrap_o=0. load and inc/dec are ignored that cycle.
- load=1 (clr=0): each digit takes its load_val digit. Any digit >= RADIX is clamped to RADIX-1. wrap_o unchanged. inc/dec are ignored.
- Step direction: inc&~dec is up; dec&~inc is down; inc&dec or neither is hold. No carry/borrow in the hold cases.
- Up step, per digit:
  - Digit 0 always steps.
  - Digit i>0 steps only when digits 0..i-1 are all RADIX-1.
  - A stepping digit at RADIX-1 goes to 0; otherwise it adds 1.
- Down step, per digit:
  - Digit i>0 steps only when digits 0..i-1 are all 0.
  - A stepping digit at 0 goes to RADIX-1; otherwise it subtracts 1.
- Latency: one clock from inc/dec/load/clr to the updated count. The whole chain updates in the same cycle; there is no per-digit pipelining.
- carry_o = up step & all digits RADIX-1 & ~load & ~clr & rst_n. It is valid in the same cycle as inc.
- borrow_o = down step & all digits 0 & ~load & ~clr & rst_n.
- wrap_o is set on the edge where carry_o|borrow_o=1. It is cleared only by reset or clr.
- zero_o is decoded from the registered count.
- Width rule: digit arithmetic is WIDTH bits. Compares against RADIX-1 and clamps use WIDTH-bit constants. No overflow is possible because digits stay within 0..RADIX-1.
- Reset or clr mid-count discards any pending step. No residual carry remains.

Optional Feature:
Macro CNT_SATURATE_EN.
- Defined:
  - An up step at all-max holds count at all-max.
  - A down step at all-zero holds count at 0.
  - carry_o/borrow_o still assert for that cycle and wrap_o still sets; they now mean "saturated".
  - Steps that do not saturate behave as normal cascaded steps.
- Undefined: wrap-around behaviour as specified in Behaviour.

Test Plan:
Defaults DIGITS=4, RADIX=10, WIDTH=4 unless stated; values are shown per digit, most significant first.
- Reset/clear: hold rst_n=0 two cycles with inc=1 -> count=0000, wrap_o=0, zero_o=1. Load 0123, pulse clr with inc=1 -> 0000, wrap_o=0.
- Cascade up: load 0999, inc one cycle -> 1000, carry_o=0. Load 9999, inc -> carry_o=1 that cycle, then 0000, wrap_o=1.
- Cascade down: from 0000, dec -> borrow_o=1, then 9999, wrap_o=1. Load 1000, dec -> 0999.
- Simultaneous and priority:
  - inc=dec=1 at 0005 -> stays 0005, no carry.
  - load=1 with inc=1, load_val=0042 -> 0042.
  - clr=1 with load=1 -> 0000.
- Load clamp: load_val digits {F,A,3,9} -> count 9939. With RADIX=16 the same load -> FA39. 0xFFFF plus inc -> 0000, carry_o=1.
- CNT_SATURATE_EN build: at 9999, inc 3 cycles -> stays 9999, carry_o=1 each cycle, wrap_o=1. At 0000, dec -> stays 0000, borrow_o=1.
